// File: rtl/write_resp_channel_arb_if.sv
// write_resp_channel_arb_if
//   Bundles the two slave-side B channels, the selected-response channel
//   toward the write-response decoder, and the debug error counter.
//   Ports (all signals):
//     M0x_AXI_bvalid/bid/bresp  slave response in; M0x_AXI_bready back to slave
//     Sel_Valid/Sel_Resp_ID/Sel_Write_Resp  buffered response out; Sel_Ready in
//     Resp_Err_Count  saturating count of accepted SLVERR/DECERR responses
//   Modports:
//     slave  - the arbiter's view (consumes slave responses, drives Sel_*)
//     master - the surrounding fabric's view (the mirror image)
interface write_resp_channel_arb_if #(
    parameter int Master_ID_Width = 1,
    parameter int Err_Count_Width = 8
);
    logic                       M00_AXI_bvalid;
    logic [Master_ID_Width-1:0] M00_AXI_bid;
    logic [1:0]                 M00_AXI_bresp;
    logic                       M00_AXI_bready;

    logic                       M01_AXI_bvalid;
    logic [Master_ID_Width-1:0] M01_AXI_bid;
    logic [1:0]                 M01_AXI_bresp;
    logic                       M01_AXI_bready;

    logic                       Sel_Valid;
    logic [Master_ID_Width-1:0] Sel_Resp_ID;
    logic [1:0]                 Sel_Write_Resp;
    logic                       Sel_Ready;

    logic [Err_Count_Width-1:0] Resp_Err_Count;

    modport slave (
        input  M00_AXI_bvalid, M00_AXI_bid, M00_AXI_bresp,
        output M00_AXI_bready,
        input  M01_AXI_bvalid, M01_AXI_bid, M01_AXI_bresp,
        output M01_AXI_bready,
        output Sel_Valid, Sel_Resp_ID, Sel_Write_Resp,
        input  Sel_Ready,
        output Resp_Err_Count
    );

    modport master (
        output M00_AXI_bvalid, M00_AXI_bid, M00_AXI_bresp,
        input  M00_AXI_bready,
        output M01_AXI_bvalid, M01_AXI_bid, M01_AXI_bresp,
        input  M01_AXI_bready,
        input  Sel_Valid, Sel_Resp_ID, Sel_Write_Resp,
        output Sel_Ready,
        input  Resp_Err_Count
    );
endinterface

// File: rtl/write_resp_channel_arb.sv
// write_resp_channel_arb
//   Round-robin arbiter for two B-channel responses feeding a one-entry
//   output register (the selected response) toward the write-response
//   decoder. Back-to-back throughput: a new response loads in the same
//   cycle the held one is accepted. Also keeps a saturating count of
//   accepted SLVERR/DECERR responses.
//   Ports:
//     ACLK    clock, rising edge
//     ARESET  synchronous reset, active-high
//     bus     write_resp_channel_arb_if.slave (slave B channels, Sel_*,
//             Resp_Err_Count)
//
//   state | meaning
//   ------+------------------------------------------------
//   EMPTY | no response held, Sel_Valid=0
//   FULL  | response held and presented, Sel_Valid=1
module write_resp_channel_arb #(
    parameter int Num_Of_Slaves   = 2,
    parameter int Master_ID_Width = 1,
    parameter int Err_Count_Width = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    write_resp_channel_arb_if.slave   bus
);
    localparam int PTR_W = (Num_Of_Slaves > 1) ? $clog2(Num_Of_Slaves) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           rr_ptr;
    logic [Master_ID_Width-1:0] sel_resp_id;
    logic [1:0]                 sel_write_resp;
    logic [Err_Count_Width-1:0] resp_err_count;

    logic [1:0] bvalid;
    logic [1:0] grant;
    logic       load_en;
    logic       load;
    logic       winner;
    logic [Master_ID_Width-1:0] win_id;
    logic [1:0] win_resp;

    assign bvalid = {bus.M01_AXI_bvalid, bus.M00_AXI_bvalid};

    // Reset gates load_en so no slave handshake completes in a reset cycle.
    assign load_en = !ARESET && ((state_q == EMPTY) || bus.Sel_Ready);

    // First valid slave at or after rr_ptr wins.
    always_comb begin
        grant = 2'b00;
        if (rr_ptr == '0) begin
            grant[0] = bvalid[0];
            grant[1] = bvalid[1] && !bvalid[0];
        end else begin
            grant[1] = bvalid[1];
            grant[0] = bvalid[0] && !bvalid[1];
        end
    end

    assign load   = load_en && (grant != 2'b00);
    assign winner = grant[1];

    assign win_id   = winner ? bus.M01_AXI_bid   : bus.M00_AXI_bid;
    assign win_resp = winner ? bus.M01_AXI_bresp : bus.M00_AXI_bresp;

    assign bus.M00_AXI_bready = load_en && grant[0];
    assign bus.M01_AXI_bready = load_en && grant[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL: begin
                if (bus.Sel_Ready) state_d = load ? FULL : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q        <= EMPTY;
            rr_ptr         <= '0;
            sel_resp_id    <= '0;
            sel_write_resp <= 2'b00;
            resp_err_count <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sel_resp_id    <= win_id;
                sel_write_resp <= win_resp;
                rr_ptr         <= PTR_W'(!winner);
                // bresp[1] marks SLVERR/DECERR; stick at all-ones instead of wrapping.
                if (win_resp[1] && (resp_err_count != '1))
                    resp_err_count <= resp_err_count + Err_Count_Width'(1);
            end
        end
    end

    assign bus.Sel_Valid      = (state_q == FULL);
    assign bus.Sel_Resp_ID    = sel_resp_id;
    assign bus.Sel_Write_Resp = sel_write_resp;
    assign bus.Resp_Err_Count = resp_err_count;
endmodule

// File: tb/tb_write_resp_channel_arb.sv
// tb_write_resp_channel_arb
//   Directed bench for write_resp_channel_arb. Two instances share the same
//   stimulus: dut_a with an 8-bit error counter, dut_b with a 2-bit one for
//   the saturation check. Inputs change 1 ns after the rising edge; combinational
//   outputs are sampled 1 ns later, registered outputs 1 ns after the edge.
module tb_write_resp_channel_arb;
    logic ACLK;
    logic ARESET;

    int n_cmp;
    int n_err;

    write_resp_channel_arb_if #(.Master_ID_Width(1), .Err_Count_Width(8)) ifa ();
    write_resp_channel_arb_if #(.Master_ID_Width(1), .Err_Count_Width(2)) ifb ();

    write_resp_channel_arb #(
        .Num_Of_Slaves(2), .Master_ID_Width(1), .Err_Count_Width(8)
    ) dut_a (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (ifa.slave)
    );

    write_resp_channel_arb #(
        .Num_Of_Slaves(2), .Master_ID_Width(1), .Err_Count_Width(2)
    ) dut_b (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (ifb.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive both instances identically, then wait for combinational settle.
    task automatic drv(input logic v0, input logic id0, input logic [1:0] r0,
                       input logic v1, input logic id1, input logic [1:0] r1,
                       input logic sr);
        ifa.M00_AXI_bvalid = v0; ifa.M00_AXI_bid = id0; ifa.M00_AXI_bresp = r0;
        ifa.M01_AXI_bvalid = v1; ifa.M01_AXI_bid = id1; ifa.M01_AXI_bresp = r1;
        ifa.Sel_Ready      = sr;
        ifb.M00_AXI_bvalid = v0; ifb.M00_AXI_bid = id0; ifb.M00_AXI_bresp = r0;
        ifb.M01_AXI_bvalid = v1; ifb.M01_AXI_bid = id1; ifb.M01_AXI_bresp = r1;
        ifb.Sel_Ready      = sr;
        #1;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reset cycle with both slaves valid and Sel_Ready high: no bready allowed.
    task automatic do_reset();
        ARESET = 1'b1;
        drv(1, 0, 2'b00, 1, 1, 2'b00, 1);
        check_val("rst_bready0", ifa.M00_AXI_bready, 0);
        check_val("rst_bready1", ifa.M01_AXI_bready, 0);
        tick();
        ARESET = 1'b0;
        drv(0, 0, 2'b00, 0, 0, 2'b00, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ARESET = 1'b1;
        drv(0, 0, 2'b00, 0, 0, 2'b00, 0);
        tick();

        // Reset state
        do_reset();
        check_val("rst_valid", ifa.Sel_Valid, 0);
        check_val("rst_id",    ifa.Sel_Resp_ID, 0);
        check_val("rst_resp",  ifa.Sel_Write_Resp, 0);
        check_val("rst_cnt",   ifa.Resp_Err_Count, 0);

        // Single response from M00
        drv(1, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("single_bready0", ifa.M00_AXI_bready, 1);
        check_val("single_bready1", ifa.M01_AXI_bready, 0);
        tick();
        drv(0, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("single_valid", ifa.Sel_Valid, 1);
        check_val("single_id",    ifa.Sel_Resp_ID, 0);
        check_val("single_resp",  ifa.Sel_Write_Resp, 0);
        tick();
        check_val("single_drain", ifa.Sel_Valid, 0);

        // Contention: strict alternation starting with M00
        do_reset();
        drv(1, 0, 2'b00, 1, 1, 2'b01, 1);
        for (int i = 0; i < 4; i++) begin
            check_val("rr_bready0", ifa.M00_AXI_bready, (i % 2 == 0) ? 1 : 0);
            check_val("rr_bready1", ifa.M01_AXI_bready, (i % 2 == 1) ? 1 : 0);
            tick();
            check_val("rr_valid", ifa.Sel_Valid, 1);
            check_val("rr_id",    ifa.Sel_Resp_ID, i % 2);
            check_val("rr_resp",  ifa.Sel_Write_Resp, (i % 2 == 1) ? 2'b01 : 2'b00);
        end
        drv(0, 0, 2'b00, 0, 0, 2'b00, 1);
        tick();
        check_val("rr_drain_valid", ifa.Sel_Valid, 0);
        check_val("rr_hold_id",     ifa.Sel_Resp_ID, 1);
        check_val("rr_hold_resp",   ifa.Sel_Write_Resp, 2'b01);

        // Backpressure: hold M01's response while M00 waits
        do_reset();
        drv(0, 0, 2'b00, 1, 1, 2'b01, 1);
        check_val("bp_load_bready1", ifa.M01_AXI_bready, 1);
        tick();
        drv(1, 0, 2'b00, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            check_val("bp_bready0", ifa.M00_AXI_bready, 0);
            check_val("bp_bready1", ifa.M01_AXI_bready, 0);
            check_val("bp_valid",   ifa.Sel_Valid, 1);
            check_val("bp_id",      ifa.Sel_Resp_ID, 1);
            check_val("bp_resp",    ifa.Sel_Write_Resp, 2'b01);
            tick();
        end
        drv(1, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("bp_release_bready0", ifa.M00_AXI_bready, 1);
        tick();
        drv(0, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("bp_next_valid", ifa.Sel_Valid, 1);
        check_val("bp_next_id",    ifa.Sel_Resp_ID, 0);
        check_val("bp_next_resp",  ifa.Sel_Write_Resp, 2'b00);
        tick();
        check_val("bp_drain", ifa.Sel_Valid, 0);

        // Error counter: SLVERR, DECERR, OKAY back-to-back from M00
        do_reset();
        drv(1, 0, 2'b10, 0, 0, 2'b00, 1);
        tick();
        check_val("err_cnt1", ifa.Resp_Err_Count, 1);
        drv(1, 0, 2'b11, 0, 0, 2'b00, 1);
        tick();
        check_val("err_resp2", ifa.Sel_Write_Resp, 2'b11);
        drv(1, 0, 2'b00, 0, 0, 2'b00, 1);
        tick();
        drv(0, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("err_resp3", ifa.Sel_Write_Resp, 2'b00);
        check_val("err_cnt3",  ifa.Resp_Err_Count, 2);
        tick();

        // Saturation: five error responses, 2-bit counter stops at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, (i % 2 == 0) ? 2'b10 : 2'b11, 0, 0, 2'b00, 1);
            tick();
            check_val("sat_cnt_b", ifb.Resp_Err_Count, (i + 1 > 3) ? 3 : i + 1);
        end
        drv(0, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("sat_cnt_a", ifa.Resp_Err_Count, 5);
        tick();

        // Reset while a response is held
        do_reset();
        drv(1, 0, 2'b10, 0, 0, 2'b00, 1);
        tick();
        drv(1, 0, 2'b00, 0, 0, 2'b00, 0);
        check_val("mid_valid", ifa.Sel_Valid, 1);
        check_val("mid_cnt",   ifa.Resp_Err_Count, 1);
        tick();
        ARESET = 1'b1;
        drv(1, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("mid_rst_bready0", ifa.M00_AXI_bready, 0);
        tick();
        ARESET = 1'b0;
        drv(1, 0, 2'b00, 1, 1, 2'b01, 1);
        check_val("mid_after_valid", ifa.Sel_Valid, 0);
        check_val("mid_after_cnt",   ifa.Resp_Err_Count, 0);
        check_val("mid_after_bready0", ifa.M00_AXI_bready, 1);
        check_val("mid_after_bready1", ifa.M01_AXI_bready, 0);
        tick();
        drv(0, 0, 2'b00, 0, 0, 2'b00, 1);
        check_val("mid_after_id", ifa.Sel_Resp_ID, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/write_resp_channel_arb.md
# write_resp_channel_arb

Upstream stage of the interconnect write-response path: arbitrates B-channel responses from the slave-side ports, buffers the winning response in a one-entry output register and presents it as the selected response (Sel_Valid / Sel_Resp_ID / Sel_Write_Resp) to the write-response decoder, which routes it to the owning master. Round-robin arbitration with back-to-back throughput, AXI-compliant valid/ready handshakes on both sides, and a saturating error-response counter for debug.

## Interface
- Num_Of_Slaves, 2: number of slave-side B-channel inputs. Fixed at 2 in this revision.
- Master_ID_Width, 1: width of bid and Sel_Resp_ID; the value identifies the destination master.
- Err_Count_Width, 8: width of the error-response counter.

- ACLK  in  1  clock. One clock domain; all logic on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- M00_AXI_bvalid  in  1  slave 0 response valid.
- M00_AXI_bid  in  Master_ID_Width  slave 0 response ID (destination master).
- M00_AXI_bresp  in  2  slave 0 response code.
- M00_AXI_bready  out  1  ready to slave 0.
- M01_AXI_bvalid, M01_AXI_bid, M01_AXI_bresp, M01_AXI_bready: same as above, slave 1.
- Sel_Valid  out  1  buffered response valid, to decoder.
- Sel_Resp_ID  out  Master_ID_Width  buffered response ID.
- Sel_Write_Resp  out  2  buffered response code.
- Sel_Ready  in  1  destination master has accepted (bready of the master addressed by Sel_Resp_ID, muxed externally).
- Resp_Err_Count  out  Err_Count_Width  count of accepted SLVERR/DECERR responses.

## Operation
- Output register states: EMPTY (Sel_Valid=0) and FULL (Sel_Valid=1).
- load_en = !ARESET & (!Sel_Valid | Sel_Ready).
- Grant is combinational over the current bvalid inputs. Starting from the priority pointer rr_ptr, select the first slave with bvalid=1; if none, there is no grant.
- Mx_AXI_bready = load_en & grant[x]. At most one bready is high per cycle, and never without a matching bvalid.
- Load occurs when a grant exists and load_en is high. On load:
  - capture the winner's bid into Sel_Resp_ID and bresp into Sel_Write_Resp;
  - set Sel_Valid=1;
  - set rr_ptr = (winner+1) mod Num_Of_Slaves.
- Sel_Ready with Sel_Valid=1 and no grant: Sel_Valid goes to 0. The data fields hold their last values.
- Sel_Ready with Sel_Valid=1 and a grant: the next response loads in the same cycle (FULL to FULL), with no bubble.
- While Sel_Valid=1 and Sel_Ready=0, Sel_Resp_ID and Sel_Write_Resp hold stable and every bready is 0.
- Sel_Ready while Sel_Valid=0 is ignored.
- rr_ptr is unchanged in any cycle without a load.
- Resp_Err_Count increments by 1 on each load where bresp[1]=1 (SLVERR 2'b10, DECERR 2'b11). It saturates at all-ones, with no wrap.
- Reset values: Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=2'b00, rr_ptr=0 (slave 0 highest priority), Resp_Err_Count=0. Both bready outputs are 0 during reset.
- Reset mid-operation: any held response is discarded without delivery. No slave handshake completes in a reset cycle.

## Timing
- Latency: a slave bvalid with the register EMPTY gives bready in the same cycle (cycle t) and Sel_Valid=1 at t+1.
- Throughput: one response per cycle while Sel_Ready stays high and bvalid inputs are present.
- bready depends combinationally on bvalid, Sel_Valid, Sel_Ready and rr_ptr. There is no combinational path from any bid or bresp to any output.
- Simultaneous bvalid on both slaves: the slave at or after rr_ptr wins. The loser keeps bvalid asserted and is granted at the next load (strict alternation under sustained contention).
- Resp_Err_Count is registered and updates the cycle after the load.

## Test plan
- Single response:
  - Stimulus: after reset, M00 bvalid=1, bid=0, bresp=2'b00 for one cycle; Sel_Ready=1.
  - Required: M00_AXI_bready=1 that cycle; next cycle Sel_Valid=1, Sel_Resp_ID=0, Sel_Write_Resp=00; Sel_Valid=0 the cycle after.
- Contention and round-robin:
  - Stimulus: M00 (bid 0, OKAY) and M01 (bid 1, EXOKAY 2'b01) both held valid; Sel_Ready=1.
  - Required: M00 granted first, then M01, then M00, alternating one per cycle; Sel_Resp_ID sequence 0,1,0,…
- Backpressure:
  - Stimulus: load M01 (bid 1, bresp 2'b01); hold Sel_Ready=0 for 4 cycles while M00 is valid.
  - Required: Sel_* outputs stable at 1/01 throughout; both bready=0. On Sel_Ready=1, M00 loads in that same cycle.
- Error counter:
  - Stimulus: feed 3 responses with bresp 10, 11, 00.
  - Required: Resp_Err_Count reads 2. With Err_Count_Width=2 and 5 error responses, it saturates at 3.
- Reset mid-hold:
  - Stimulus: Sel_Valid=1, Sel_Ready=0; assert ARESET for 1 cycle with M00 bvalid=1.
  - Required: M00_AXI_bready=0 in the reset cycle; after reset Sel_Valid=0, Resp_Err_Count=0 and rr_ptr=0 (with both slaves valid, M00 wins first).
